// File: rtl/lii_out_arbiter.sv
// lii_out_arbiter
//   Round-robin arbiter that shares one LII physical output channel among N
//   kernel-wrapper output streams. Forwarded beats pass through a single
//   registered output stage.
//
//   Build option: define LII_ARB_BURST_EN to let a grantee send up to BURST
//   beats per grant. Left undefined, every accepted beat releases the grant
//   (single-beat round-robin) and BURST is ignored.
//
// Ports
//   aclk            clock, rising edge
//   arst            synchronous active-high reset
//   req_tdata       N x PW requester data, slice i = [i*PW +: PW]
//   req_tvalid      N requester valid
//   req_tready      N requester ready
//   req_src         N x 8 requester source tag
//   req_dst         N x 8 requester destination tag
//   lii_out_tdata   registered output data
//   lii_out_tvalid  registered output valid
//   lii_out_tready  downstream ready
//   lii_out_src     registered source tag
//   lii_out_dst     registered destination tag
//   grant_id        index of current or last grantee
//   busy            high while a grant is held
//
// State | meaning
// IDLE  | no grant; scan req_tvalid from rr_ptr for the next grantee
// GRANT | grant_id owns the channel until its beat limit or it idles
module lii_out_arbiter #(
    parameter int N     = 4,
    parameter int PW    = 1024,
    parameter int BURST = 4,
    localparam int GW   = $clog2(N)
) (
    input  logic            aclk,
    input  logic            arst,
    input  logic [N*PW-1:0] req_tdata,
    input  logic [N-1:0]    req_tvalid,
    output logic [N-1:0]    req_tready,
    input  logic [N*8-1:0]  req_src,
    input  logic [N*8-1:0]  req_dst,
    output logic [PW-1:0]   lii_out_tdata,
    output logic            lii_out_tvalid,
    input  logic            lii_out_tready,
    output logic [7:0]      lii_out_src,
    output logic [7:0]      lii_out_dst,
    output logic [GW-1:0]   grant_id,
    output logic            busy
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state, state_nxt;
    logic [GW-1:0] rr_ptr, rr_ptr_nxt;
    logic [GW-1:0] grant_id_nxt;
    logic          load;
    logic          accept;
    logic          sel_valid;
    logic [PW-1:0] sel_data;
    logic [7:0]    sel_src;
    logic [7:0]    sel_dst;
    logic          pick_found;
    logic [GW-1:0] pick_idx;
    int            scan_idx;
`ifdef LII_ARB_BURST_EN
    logic [7:0]    beat_cnt, beat_cnt_nxt;
`endif

    assign load   = !lii_out_tvalid || lii_out_tready;
    assign busy   = (state == GRANT);
    assign accept = busy && load && sel_valid;

    // Grantee mux; ready depends only on state and downstream ready.
    always_comb begin
        sel_valid  = 1'b0;
        sel_data   = '0;
        sel_src    = '0;
        sel_dst    = '0;
        req_tready = '0;
        for (int i = 0; i < N; i++) begin
            if (GW'(i) == grant_id) begin
                sel_valid     = req_tvalid[i];
                sel_data      = req_tdata[i*PW +: PW];
                sel_src       = req_src[i*8 +: 8];
                sel_dst       = req_dst[i*8 +: 8];
                req_tready[i] = busy && load;
            end
        end
    end

    // First valid requester at or after rr_ptr, wrapping modulo N.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan_idx   = 0;
        for (int k = 0; k < N; k++) begin
            scan_idx = int'(rr_ptr) + k;
            if (scan_idx >= N) scan_idx = scan_idx - N;
            if (!pick_found && req_tvalid[GW'(scan_idx)]) begin
                pick_found = 1'b1;
                pick_idx   = GW'(scan_idx);
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        rr_ptr_nxt   = rr_ptr;
        grant_id_nxt = grant_id;
`ifdef LII_ARB_BURST_EN
        beat_cnt_nxt = beat_cnt;
`endif
        case (state)
            IDLE: begin
                if (pick_found) begin
                    grant_id_nxt = pick_idx;
                    state_nxt    = GRANT;
`ifdef LII_ARB_BURST_EN
                    beat_cnt_nxt = 8'd0;
`endif
                end
            end
            GRANT: begin
                // A stall (load=0) never releases; otherwise release on the
                // limit-reaching beat or when the grantee has nothing to send.
                if (load) begin
`ifdef LII_ARB_BURST_EN
                    if (sel_valid) begin
                        beat_cnt_nxt = beat_cnt + 8'd1;
                        if (beat_cnt_nxt == 8'(BURST)) state_nxt = IDLE;
                    end else begin
                        state_nxt = IDLE;
                    end
`else
                    state_nxt = IDLE;
`endif
                    if (state_nxt == IDLE) begin
                        rr_ptr_nxt = (grant_id == GW'(N - 1)) ? '0 : grant_id + GW'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (arst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
`ifdef LII_ARB_BURST_EN
            beat_cnt <= 8'd0;
`endif
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_ptr_nxt;
            grant_id <= grant_id_nxt;
`ifdef LII_ARB_BURST_EN
            beat_cnt <= beat_cnt_nxt;
`endif
        end
    end

    // Output stage: reloads whenever empty or draining; holds under stall.
    always_ff @(posedge aclk) begin
        if (arst) begin
            lii_out_tvalid <= 1'b0;
            lii_out_tdata  <= '0;
            lii_out_src    <= '0;
            lii_out_dst    <= '0;
        end else if (load) begin
            lii_out_tvalid <= accept;
            if (accept) begin
                lii_out_tdata <= sel_data;
                lii_out_src   <= sel_src;
                lii_out_dst   <= sel_dst;
            end
        end
    end

endmodule

// File: doc/lii_out_arbiter.md
Name: lii_out_arbiter

Overview:
- Shares one LII physical output channel among N kernel wrappers (logic output streams).
- Each requester presents PW-bit data plus 8-bit src/dst tags; the block grants the channel round-robin.
- Forwarded beats pass through a single registered output stage toward the LII fabric.
- Sits between the per-kernel wrapper outputs and one phy out channel, where Q < number of logic outputs.

Parameters:
- N, 4, number of requesters (2..16).
- PW, 1024, packing width of each beat.
- BURST, 4, maximum beats accepted per grant when LII_ARB_BURST_EN is defined (1..255).
- GW, $clog2(N), grant index width (derived; do not override).

Ports:
- aclk  in  1  clock, all logic on rising edge.
- arst  in  1  synchronous active-high reset.
- req_tdata  in  N*PW  requester data; slice i = [i*PW +: PW].
- req_tvalid  in  N  requester valid.
- req_tready  out  N  requester ready.
- req_src  in  N*8  requester source tag, slice i = [i*8 +: 8].
- req_dst  in  N*8  requester destination tag.
- lii_out_tdata  out  PW  registered output data.
- lii_out_tvalid  out  1  registered output valid.
- lii_out_tready  in  1  downstream ready.
- lii_out_src  out  8  registered source tag.
- lii_out_dst  out  8  registered destination tag.
- grant_id  out  GW  index of current or last grantee.
- busy  out  1  high in GRANT state.

Behaviour:
- Reset (arst=1 at an edge):
  - state=IDLE, rr_ptr=0, beat_cnt=0, grant_id=0, busy=0.
  - lii_out_tvalid=0; lii_out_tdata, src and dst = 0; req_tready all 0.
  - Reset mid-burst drops any beat held in the output register; it is not replayed.
- Output register:
  - load = !lii_out_tvalid | lii_out_tready.
  - When load is asserted and a beat is accepted: tdata, src and dst are captured and lii_out_tvalid is set to 1.
  - When load is asserted and no beat is accepted: lii_out_tvalid is cleared to 0.
  - While lii_out_tvalid=1 and lii_out_tready=0, all output registers hold stable.
- Readiness and acceptance:
  - req_tready[i] = (state==GRANT) & (i==grant_id) & load. It is combinational from state and lii_out_tready; there is no combinational path from req_tvalid.
  - A beat is accepted when req_tvalid[i] & req_tready[i].
  - Latency from acceptance to appearance on lii_out is 1 cycle.
- FSM state IDLE:
  - If any req_tvalid is high, pick the first valid index searching from rr_ptr upward, wrapping modulo N.
  - Register it into grant_id, clear beat_cnt and go to GRANT.
  - Otherwise stay in IDLE.
  - Arbitration uses req_tvalid sampled in that cycle; there are no tready in IDLE.
- FSM state GRANT (busy=1):
  - Each accepted beat increments beat_cnt (8-bit).
  - Release when an accepted beat makes beat_cnt reach the burst limit, OR when load=1 and req_tvalid[grant_id]=0 (the requester idled while the channel was free).
  - A stall (load=0) never causes release.
  - On release: rr_ptr = (grant_id+1) mod N (wrap from N-1 to 0), state returns to IDLE.
  - Every re-arbitration therefore costs exactly one idle cycle.
- Fairness:
  - A continuously-valid requester waits at most (N-1)*(limit+1) accepting cycles.
  - Simultaneous requests are resolved purely by rr_ptr; there is no fixed priority.
- Other rules:
  - src and dst pass through unchanged; the block never inspects or modifies them.
  - Non-granted requesters see tready=0 and must hold their data (AXI-Stream rules). The arbiter does not check this.

Optional Feature:
- Macro LII_ARB_BURST_EN.
- Defined: the burst limit is BURST.
- Undefined: the burst limit is 1. Every accepted beat releases the grant (single-beat round-robin), beat_cnt is optimised away, and the BURST parameter is ignored.

Test Plan:
- Single requester, LII_ARB_BURST_EN defined, BURST=4, N=4, PW=32. req 2 streams 0xA0..0xA7 with ready always high.
  - Expected: grant_id=2.
  - Output shows A0..A3, a 1-cycle tvalid gap, then A4..A7.
  - Data appears 1 cycle after acceptance; src/dst match the input.
- All 4 requesters continuously valid, macro defined, BURST=4, from reset.
  - Expected grant order 0,1,2,3,0; exactly 4 beats per grant; 1 idle cycle between grants; no beat lost or duplicated.
- Backpressure: lii_out_tready=0 for cycles 3..7 during a burst from req 1.
  - Expected: output registers hold their value; req_tready[1]=0 during the stall; no release.
  - After tready returns, the remaining beats arrive in order.
- Early release: req 3 sends 2 beats, then drops tvalid while tready=1, and req 0 is pending.
  - Expected: release after the gap; rr_ptr=0; req 0 granted next.
- Macro undefined, reqs 1 and 3 valid.
  - Expected: grants alternate 1,3,1,3 with one beat each.
- arst asserted mid-burst with lii_out_tvalid=1.
  - Next cycle: lii_out_tvalid=0, busy=0, grant_id=0, req_tready=0.
  - The first grant after reset goes to the lowest valid index.
